// File: rtl/updown_count_sched.sv
// Two-requester scheduler for a shared modulo (limit+1) up/down counter.
// Jobs are granted round-robin and run to completion unless reset intervenes.
module updown_count_sched #(
  parameter int CNT_W = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [CNT_W-1:0] lim0,
  input  logic             dir0,
  input  logic [LEN_W-1:0] len0,
  input  logic             req1,
  input  logic [CNT_W-1:0] lim1,
  input  logic             dir1,
  input  logic [LEN_W-1:0] len1,
  input  logic             hold,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] lim_r, lim_nxt;
  logic             dir_r, dir_nxt;
  logic [LEN_W-1:0] rem, rem_nxt;
  logic             last_srv, srv_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, wrap_nxt;

  logic             grant, pick1;
  logic [CNT_W-1:0] sel_lim;
  logic             sel_dir;
  logic [LEN_W-1:0] sel_len;

  assign busy = (state != IDLE);

  // Winner of contention is the requester that was not served last.
  always_comb begin
    grant = 1'b0;
    pick1 = 1'b0;
    if (req0 && req1) begin
      grant = 1'b1;
      pick1 = ~last_srv;
      pick1 = (last_srv == 1'b0);
    end else if (req0) begin
      grant = 1'b1;
      pick1 = 1'b0;
    end else if (req1) begin
      grant = 1'b1;
      pick1 = 1'b1;
    end
    sel_lim = pick1 ? lim1 : lim0;
    sel_dir = pick1 ? dir1 : dir0;
    sel_len = pick1 ? len1 : len0;
  end

  always_comb begin
    state_nxt = state;
    lim_nxt   = lim_r;
    dir_nxt   = dir_r;
    rem_nxt   = rem;
    srv_nxt   = last_srv;
    cnt_nxt   = cnt;
    gnt0_nxt  = 1'b0;
    gnt1_nxt  = 1'b0;
    done0_nxt = 1'b0;
    done1_nxt = 1'b0;
    wrap_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          gnt0_nxt  = ~pick1;
          gnt1_nxt  = pick1;
          lim_nxt   = sel_lim;
          dir_nxt   = sel_dir;
          rem_nxt   = sel_len;
          srv_nxt   = pick1;
          cnt_nxt   = sel_dir ? '0 : sel_lim;
          state_nxt = (sel_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (!hold) begin
          if (dir_r) begin
            if (cnt == lim_r) begin
              cnt_nxt  = '0;
              wrap_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt + CNT_W'(1);
            end
          end else begin
            if (cnt == '0) begin
              cnt_nxt  = lim_r;
              wrap_nxt = 1'b1;
            end else begin
              cnt_nxt = cnt - CNT_W'(1);
            end
          end
          rem_nxt = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) state_nxt = DONE;
        end
      end
      DONE: begin
        done0_nxt = ~last_srv;
        done1_nxt = last_srv;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lim_r    <= '0;
      dir_r    <= 1'b0;
      rem      <= '0;
      last_srv <= 1'b1;
      cnt      <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nxt;
      lim_r    <= lim_nxt;
      dir_r    <= dir_nxt;
      rem      <= rem_nxt;
      last_srv <= srv_nxt;
      cnt      <= cnt_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      done0    <= done0_nxt;
      done1    <= done1_nxt;
      wrap     <= wrap_nxt;
    end
  end

endmodule

// File: tb/tb_updown_count_sched.sv
// Directed self-checking bench for updown_count_sched.
module tb_updown_count_sched;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, dir0, req1, dir1, hold;
  logic [3:0] lim0, lim1;
  logic [7:0] len0, len1;
  logic       gnt0, gnt1, done0, done1, busy, wrap;
  logic [3:0] cnt;

  int checks = 0;
  int errors = 0;

  updown_count_sched #(.CNT_W(4), .LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .lim0(lim0), .dir0(dir0), .len0(len0),
    .req1(req1), .lim1(lim1), .dir1(dir1), .len1(len1),
    .hold(hold),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .cnt(cnt), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int e1[8];
    int e2[5];
    e1 = '{1, 2, 3, 4, 5, 0, 1, 2};
    e2 = '{2, 1, 0, 3, 2};
    rst_n = 1'b0; hold = 1'b0;
    req0 = 1'b0; lim0 = '0; dir0 = 1'b0; len0 = '0;
    req1 = 1'b0; lim1 = '0; dir1 = 1'b0; len1 = '0;
    #12;
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {gnt0, gnt1, done0, done1, wrap}, 0);
    rst_n = 1'b1;

    // Job 0: up, lim 5, 8 steps
    req0 = 1'b1; lim0 = 4'd5; dir0 = 1'b1; len0 = 8'd8;
    tick();
    chk("j0_gnt0", gnt0, 1);
    chk("j0_gnt1", gnt1, 0);
    chk("j0_start", cnt, 0);
    chk("j0_busy", busy, 1);
    req0 = 1'b0; lim0 = 4'd9; dir0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("j0_cnt", cnt, e1[i]);
      chk("j0_wrap", wrap, (i == 5) ? 1 : 0);
      chk("j0_nodone", done0, 0);
    end
    chk("j0_busy_done_state", busy, 1);
    tick();
    chk("j0_done0", done0, 1);
    chk("j0_done1", done1, 0);
    chk("j0_busy_low", busy, 0);
    chk("j0_hold_cnt", cnt, 2);

    // Job 1: down, lim 3, 5 steps
    req1 = 1'b1; lim1 = 4'd3; dir1 = 1'b0; len1 = 8'd5;
    tick();
    chk("j1_gnt1", gnt1, 1);
    chk("j1_done0_clr", done0, 0);
    chk("j1_start", cnt, 3);
    req1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("j1_cnt", cnt, e2[i]);
      chk("j1_wrap", wrap, (i == 3) ? 1 : 0);
    end
    tick();
    chk("j1_done1", done1, 1);
    chk("j1_done0", done0, 0);
    tick();
    chk("j1_done1_once", done1, 0);

    // Contention after reset
    rst_n = 1'b0; #2; rst_n = 1'b1;
    req0 = 1'b1; lim0 = 4'd2; dir0 = 1'b1; len0 = 8'd1;
    req1 = 1'b1; lim1 = 4'd2; dir1 = 1'b1; len1 = 8'd1;
    tick();
    chk("rr_first_gnt0", gnt0, 1);
    chk("rr_first_gnt1", gnt1, 0);
    req0 = 1'b0;
    tick();
    chk("rr_step", cnt, 1);
    chk("rr_no_gnt_run", gnt1, 0);
    tick();
    chk("rr_done0", done0, 1);
    chk("rr_no_gnt_done", gnt1, 0);
    tick();
    chk("rr_gnt1", gnt1, 1);
    req1 = 1'b0;
    tick();
    tick();
    chk("rr_done1", done1, 1);
    req0 = 1'b1; req1 = 1'b1;
    tick();
    chk("rr_again_gnt0", gnt0, 1);
    chk("rr_again_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    chk("rr_again_done0", done0, 1);

    // Hold freezes a running job
    req0 = 1'b1; lim0 = 4'd7; dir0 = 1'b1; len0 = 8'd6;
    tick();
    chk("h_gnt0", gnt0, 1);
    req0 = 1'b0;
    tick();
    tick();
    chk("h_pre", cnt, 2);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("h_frozen_cnt", cnt, 2);
      chk("h_frozen_wrap", wrap, 0);
      chk("h_frozen_done", done0, 0);
      chk("h_frozen_busy", busy, 1);
    end
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("h_resume", cnt, 3 + i);
    end
    chk("h_no_early_done", done0, 0);
    tick();
    chk("h_done0", done0, 1);
    chk("h_final", cnt, 6);

    // Zero-length job
    req0 = 1'b1; lim0 = 4'd9; dir0 = 1'b0; len0 = 8'd0;
    tick();
    chk("z_gnt0", gnt0, 1);
    chk("z_cnt", cnt, 9);
    chk("z_done_not_yet", done0, 0);
    req0 = 1'b0;
    tick();
    chk("z_done0", done0, 1);
    chk("z_cnt_hold", cnt, 9);
    chk("z_wrap", wrap, 0);
    tick();
    chk("z_idle_cnt", cnt, 9);
    chk("z_idle_wrap", wrap, 0);

    // Asynchronous reset mid-run
    req1 = 1'b1; lim1 = 4'd7; dir1 = 1'b1; len1 = 8'd10;
    tick();
    chk("ar_gnt1", gnt1, 1);
    req1 = 1'b0;
    tick();
    tick();
    chk("ar_pre", cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt", cnt, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pulses", {gnt0, gnt1, done0, done1, wrap}, 0);
    #3 rst_n = 1'b1;
    tick();
    chk("ar_no_done", {done0, done1}, 0);
    tick();
    chk("ar_no_done2", {done0, done1}, 0);
    req0 = 1'b1; len0 = 8'd1; req1 = 1'b1;
    tick();
    chk("ar_rr_gnt0", gnt0, 1);
    chk("ar_rr_gnt1", gnt1, 0);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
